// File: rtl/iq_fetch_unit.sv
// iq_fetch_unit: PC fetch driver feeding a circular instruction queue with valid/ready issue.
// Defining IQ_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module iq_fetch_unit #(
   parameter int INSTR_W  = 32,
   parameter int PC_W     = 4,
   parameter int DEPTH    = 4,
   parameter int RESET_PC = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fetch_en,
   output logic [PC_W-1:0]            imem_addr,
   input  logic [INSTR_W-1:0]         imem_rdata,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output logic [INSTR_W-1:0]         iss_instr,
   output logic [PC_W-1:0]            iss_pc,
   input  logic                       flush,
   input  logic [PC_W-1:0]            flush_pc,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
`ifdef IQ_STALL_CNT_EN
   ,
   output logic [15:0]                stall_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);
   logic [PC_W-1:0] pc;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [PC_W+INSTR_W-1:0] mem [DEPTH];
   logic pop, push;
   assign full      = count == CW'(DEPTH);
   assign empty     = count == '0;
   assign iss_valid = !empty;
   assign pop       = iss_valid & iss_ready;
   assign push      = fetch_en & (!full | pop);
   assign imem_addr = pc;
   assign {iss_pc, iss_instr} = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc     <= RST_PC;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         pc     <= flush_pc;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            pc     <= pc + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   // storage is deliberately left uncleared; count alone decides what is visible
   always_ff @(posedge clk)
      if (push && !flush) mem[wr_ptr] <= {pc, imem_rdata};
`ifdef IQ_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) stall_cnt <= '0;
      else if (flush) stall_cnt <= '0;
      else if (fetch_en && full && !pop && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_iq_fetch_unit.sv
// tb_iq_fetch_unit: directed stimulus with a scoreboard of expected issued entries.
module tb_iq_fetch_unit;
   logic        clk = 0, rst = 1, fetch_en = 0, iss_ready = 0, flush = 0;
   logic [3:0]  flush_pc = '0, imem_addr, iss_pc;
   logic [31:0] imem_rdata, iss_instr;
   logic        iss_valid, full, empty;
   logic [2:0]  count;
`ifdef IQ_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif
   int checks = 0, errors = 0;
   logic [35:0] sb [$];

   iq_fetch_unit dut (
      .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_instr(iss_instr), .iss_pc(iss_pc), .flush(flush), .flush_pc(flush_pc),
      .full(full), .empty(empty), .count(count)
`ifdef IQ_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;
   assign imem_rdata = 32'hA000_0000 + 32'(imem_addr);

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp(input int p);
      logic [3:0] pc4;
      pc4 = p[3:0];
      sb.push_back({pc4, 32'hA000_0000 + 32'(pc4)});
   endtask

   // monitor: every accepted issue must match the oldest expected entry
   always @(negedge clk)
      if (!rst && iss_valid && iss_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got pc %0h expected none", iss_pc);
         end else
            check("issue", {iss_pc, iss_instr}, sb.pop_front());
      end

   initial begin
      step(2);
      check("rst_empty", 36'(empty), 36'd1);
      check("rst_full", 36'(full), 36'd0);
      check("rst_valid", 36'(iss_valid), 36'd0);
      check("rst_count", 36'(count), 36'd0);
      check("rst_addr", 36'(imem_addr), 36'd0);
      check("rst_head", {iss_pc, iss_instr}, 36'd0);
      rst = 0;
      fetch_en = 1;
      step(4);
      check("fill_full", 36'(full), 36'd1);
      check("fill_count", 36'(count), 36'd4);
      check("fill_addr", 36'(imem_addr), 36'd4);
      check("fill_head", {iss_pc, iss_instr}, {4'd0, 32'hA000_0000});
      step(2);
      check("hold_addr", 36'(imem_addr), 36'd4);
      check("hold_full", 36'(full), 36'd1);
      for (int i = 0; i < 4; i++) exp(i);
      iss_ready = 1;
      step(4);
      check("pp_count", 36'(count), 36'd4);
      check("pp_addr", 36'(imem_addr), 36'd8);
      check("pp_wrap_head", 36'(iss_pc), 36'd4);
      fetch_en = 0;
      exp(4);
      step(1);
      check("pop_count", 36'(count), 36'd3);
      iss_ready = 0;
      flush = 1;
      flush_pc = 4'hC;
      fetch_en = 1;
      step(1);
      flush = 0;
      fetch_en = 0;
      check("fl_empty", 36'(empty), 36'd1);
      check("fl_valid", 36'(iss_valid), 36'd0);
      check("fl_addr", 36'(imem_addr), 36'd12);
      fetch_en = 1;
      step(1);
      check("fl_head", 36'(iss_pc), 36'd12);
      check("fl_hvalid", 36'(iss_valid), 36'd1);
      for (int p = 12; p < 18; p++) exp(p);
      iss_ready = 1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         check("wrap_valid", 36'(iss_valid), 36'd1);
      end
      fetch_en = 0;
      exp(2);
      step(1);
      check("drain_empty", 36'(empty), 36'd1);
      step(2);
      check("rdy_empty_count", 36'(count), 36'd0);
      check("rdy_empty_addr", 36'(imem_addr), 36'd3);
      iss_ready = 0;
      fetch_en = 1;
      step(3);
      check("pre_rst_count", 36'(count), 36'd3);
      fetch_en = 0;
      #2 rst = 1;
      #1;
      check("arst_count", 36'(count), 36'd0);
      check("arst_valid", 36'(iss_valid), 36'd0);
      check("arst_addr", 36'(imem_addr), 36'd0);
      check("arst_head", {iss_pc, iss_instr}, 36'd0);
      step(1);
      rst = 0;
      fetch_en = 1;
      step(1);
      fetch_en = 0;
      exp(0);
      iss_ready = 1;
      step(1);
      iss_ready = 0;
      check("post_rst_empty", 36'(empty), 36'd1);
`ifdef IQ_STALL_CNT_EN
      check("stall_init", 36'(stall_cnt), 36'd0);
      fetch_en = 1;
      step(4);
      check("stall_fill", 36'(stall_cnt), 36'd0);
      step(10);
      check("stall_10", 36'(stall_cnt), 36'd10);
      exp(1);
      iss_ready = 1;
      step(1);
      iss_ready = 0;
      check("stall_pop", 36'(stall_cnt), 36'd10);
      flush = 1;
      step(1);
      flush = 0;
      fetch_en = 0;
      check("stall_flush", 36'(stall_cnt), 36'd0);
`endif
      step(2);
      check("sb_drained", 36'(sb.size()), 36'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/iq_fetch_unit.md
Name: iq_fetch_unit

Overview:
- Parametrised fetch unit plus circular instruction queue for the Tomasulo core.
- Drives the PC into instruction memory and writes returned instructions into a DEPTH-entry FIFO.
- Presents the oldest entry, with its PC, to the issue/rename stage over a valid/ready handshake.
- Adds back-pressure, simultaneous push/pop, flush/redirect and occupancy reporting.

Parameters:
- INSTR_W, 32, instruction width in bits.
- PC_W, 4, PC width; instruction memory holds 2^PC_W words.
- DEPTH, 4, queue entries; power of two, 2 or more.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  allow fetching this cycle.
- imem_addr  out  PC_W  instruction memory address; always equals pc.
- imem_rdata  in  INSTR_W  combinational memory read data for imem_addr.
- iss_valid  out  1  head entry is valid.
- iss_ready  in  1  issue stage accepts the head entry this cycle.
- iss_instr  out  INSTR_W  head instruction.
- iss_pc  out  PC_W  PC of the head instruction.
- flush  in  1  discard all queued entries and redirect the PC.
- flush_pc  in  PC_W  redirect target.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (asynchronous, any cycle, including mid-operation):
  - pc=RESET_PC, wr_ptr=0, rd_ptr=0, count=0.
  - iss_valid=0, full=0, empty=1.
  - iss_instr and iss_pc = 0 while empty.
  - Entry storage is not cleared.
- Definitions:
  - pop = iss_valid & iss_ready.
  - push = fetch_en & (!full | pop). A push into a full queue is legal only in the same cycle as a pop.
- Push, registered at the clock edge:
  - mem[wr_ptr] <= {pc, imem_rdata}.
  - wr_ptr <= wr_ptr+1 mod DEPTH.
  - pc <= pc+1 mod 2^PC_W; the PC wraps 2^PC_W-1 -> 0.
- Pop:
  - rd_ptr <= rd_ptr+1 mod DEPTH.
  - iss_instr/iss_pc come combinationally from mem[rd_ptr].
  - An entry is visible at the issue side 1 cycle after its push; there is no bypass.
- Count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- fetch_en=1 while full with no pop: pc holds, no write, full stays 1. A stall cycle is defined as fetch_en & full & !pop.
- iss_ready while empty: no effect; pointers and count unchanged.
- flush has priority over push and pop in the same cycle:
  - wr_ptr=rd_ptr=0, count=0.
  - pc <= flush_pc.
  - The next cycle has iss_valid=0 and imem_addr=flush_pc.
- full, empty and iss_valid are decoded from registered count; they never depend combinationally on iss_ready or fetch_en.
- Pointers wrap naturally mod DEPTH. count distinguishes full from empty when the pointers are equal.

Optional Feature:
- Macro: IQ_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt (16 bits).
  - stall_cnt increments on each stall cycle and saturates at 16'hFFFF.
  - Reset and flush both clear stall_cnt to 0.
- Undefined: the port and its counter do not exist; all other behaviour is identical.

Test Plan:
- Default parameters, imem[i]=32'hA000_0000+i, fetch_en=1, iss_ready=0 -> after 4 edges full=1, count=4, pc=4, iss_instr=32'hA000_0000, iss_pc=0; further cycles leave pc at 4.
- From the full state, iss_ready=1 and fetch_en=1 for 4 cycles -> count stays 4; iss_pc steps 0,1,2,3; pc reaches 8; mem[0] is overwritten with PC 4.
- Queue holds PCs 5..7, assert flush with flush_pc=4'hC -> next cycle empty=1, iss_valid=0, imem_addr=12; with fetch_en=1, 1 cycle later iss_pc=12.
- Fetch continuously with iss_ready=1 from pc=13 -> issued PCs are 13,14,15,0,1; no gap across the wrap.
- Queue at count=3, assert rst asynchronously mid-cycle -> outputs reset immediately; after release the first issued iss_pc=RESET_PC.
- With IQ_STALL_CNT_EN defined: hold full with fetch_en=1 for 10 cycles -> stall_cnt=10; one pop cycle adds nothing; flush -> stall_cnt=0.
